// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Arbitrates two writers (0: ALU result, 1: load result) onto the single
// register-file write-back port and registers the winner's address/data.
// Round-robin with a burst limit: an owner keeps the port for at most
// MAX_BURST consecutive grants while the other requester is waiting.
//
// Optional feature macro: WB_ARB_FIXED_PRIO_EN
//   defined   -> requester 1 always wins a tie; burst counter held at 0.
//   undefined -> round-robin with burst limit.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall           blocks all grants this cycle
//   v0/a0/d0/r0     requester 0 valid, dest register, data, ready (comb)
//   v1/a1/d1/r1     requester 1 valid, dest register, data, ready (comb)
//   we/waddr/wdata  registered register-file write port
//   gnt_id          registered id of the requester behind we/waddr/wdata
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              v0,
  input  logic [ADDR_W-1:0] a0,
  input  logic [DATA_W-1:0] d0,
  output logic              r0,
  input  logic              v1,
  input  logic [ADDR_W-1:0] a1,
  input  logic [DATA_W-1:0] d1,
  output logic              r1,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [1:0]        valid;
  logic [1:0]        gnt;
  logic [1:0]        owns;
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              gnt_id_reg;

  assign valid = {v1, v0};

  // owns[k] is high when requester k received the previous grant.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_own
      assign owns[gi] = (state_reg == ((gi == 0) ? OWN0 : OWN1));
    end
  endgenerate

  // Grant decision: purely from valids, stall, state and count, never from
  // address or data, so ready has no path from the payload inputs.
  always_comb begin
    gnt = 2'b00;
    if (!rst && !stall) begin
      case (valid)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
`ifdef WB_ARB_FIXED_PRIO_EN
          gnt = 2'b10;
`else
          case (state_reg)
            OWN0:    gnt = (cnt_reg < MAXB) ? 2'b01 : 2'b10;
            OWN1:    gnt = (cnt_reg < MAXB) ? 2'b10 : 2'b01;
            default: gnt = 2'b01;
          endcase
`endif
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  assign r0       = gnt[0];
  assign r1       = gnt[1];
  assign xfer     = |gnt;
  assign sel      = gnt[1];
  assign sel_addr = sel ? a1 : a0;
  assign sel_data = sel ? d1 : d0;

  // Owner/count next state. A stall freezes both so the burst position
  // survives the stall.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (!stall) begin
      if (xfer) begin
        state_next = sel ? OWN1 : OWN0;
`ifdef WB_ARB_FIXED_PRIO_EN
        cnt_next   = 4'd0;
`else
        if (owns[sel])
          cnt_next = (cnt_reg >= MAXB) ? MAXB : cnt_reg + 4'd1;
        else
          cnt_next = 4'd1;
`endif
      end else begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      gnt_id_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (xfer) begin
        // Writes to register 0 are accepted but never reach the file.
        we_reg     <= (sel_addr != '0);
        waddr_reg  <= sel_addr;
        wdata_reg  <= sel_data;
        gnt_id_reg <= sel;
      end else begin
        we_reg <= 1'b0;
      end
    end
  end

  assign we     = we_reg;
  assign waddr  = waddr_reg;
  assign wdata  = wdata_reg;
  assign gnt_id = gnt_id_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model that tracks the last
// winner and its unbounded streak length.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          r0, r1;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          gnt_id;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .we(we), .waddr(waddr), .wdata(wdata), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: last winner (-1 = none) and how many grants in a row.
  int            last_id = -1;
  int            streak  = 0;
  int            mg      = -1;
  logic          e_we;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;
  logic          e_gid;

  function automatic int model_grant();
    if (rst || stall) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (!v0 && !v1) return -1;
`ifdef WB_ARB_FIXED_PRIO_EN
    return 1;
`else
    if (last_id < 0) return 0;
    if (streak < MB) return last_id;
    return 1 - last_id;
`endif
  endfunction

  task automatic model_reset();
    last_id = -1;
    streak  = 0;
    e_we    = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
    e_gid   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check readies, clock, check write port.
  task automatic cycle(input logic s,
                       input logic vv0, input logic [AW-1:0] aa0, input logic [DW-1:0] dd0,
                       input logic vv1, input logic [AW-1:0] aa1, input logic [DW-1:0] dd1);
    stall = s; v0 = vv0; a0 = aa0; d0 = dd0; v1 = vv1; a1 = aa1; d1 = dd1;
    #1;
    mg = model_grant();
    check_val("r0", {63'd0, r0}, {63'd0, mg == 0});
    check_val("r1", {63'd0, r1}, {63'd0, mg == 1});
    @(posedge clk);
    #1;
    if (mg >= 0) begin
      e_waddr = (mg == 0) ? aa0 : aa1;
      e_wdata = (mg == 0) ? dd0 : dd1;
      e_we    = (e_waddr != '0);
      e_gid   = (mg == 1);
      streak  = (last_id == mg) ? streak + 1 : 1;
      last_id = mg;
    end else begin
      e_we = 1'b0;
      if (!s) begin
        last_id = -1;
        streak  = 0;
      end
    end
    check_val("we", {63'd0, we}, {63'd0, e_we});
    check_val("waddr", 64'(waddr), 64'(e_waddr));
    check_val("wdata", 64'(wdata), 64'(e_wdata));
    check_val("gnt_id", {63'd0, gnt_id}, {63'd0, e_gid});
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  logic [9:0]    cont_pat;
  logic          p0, p1;
  logic [AW-1:0] ra0, ra1;
  logic [DW-1:0] rd0, rd1;

  initial begin
`ifdef WB_ARB_FIXED_PRIO_EN
    cont_pat = 10'b11_1111_1111;
`else
    cont_pat = 10'b00_1111_0000;  // bit i = grant of contention cycle i
`endif
    rst = 1'b1; stall = 1'b0;
    v0 = 1'b1; v1 = 1'b1; a0 = 5'd3; a1 = 5'd4; d0 = 32'h1; d1 = 32'h2;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_r0", {63'd0, r0}, 64'd0);
    check_val("rst_r1", {63'd0, r1}, 64'd0);
    check_val("rst_we", {63'd0, we}, 64'd0);
    check_val("rst_waddr", 64'(waddr), 64'd0);
    check_val("rst_wdata", 64'(wdata), 64'd0);
    check_val("rst_gnt_id", {63'd0, gnt_id}, 64'd0);
    rst = 1'b0;

    // Single write, then the port goes quiet.
    cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check_val("single_we", {63'd0, we}, 64'd1);
    check_val("single_wdata", 64'(wdata), 64'hDEADBEEF);
    idle_cycle();
    check_val("single_we_off", {63'd0, we}, 64'd0);

    // Sustained contention.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, AW'(i + 1), DW'(32'hA000 + i), 1'b1, AW'(i + 10), DW'(32'hB000 + i));
      check_val("cont_seq", {63'd0, gnt_id}, {63'd0, cont_pat[i]});
    end
    idle_cycle();

    // Write to register 0 from requester 1 is accepted but suppressed.
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    check_val("zero_we", {63'd0, we}, 64'd0);
    idle_cycle();

    // Stall in the middle of a burst.
    for (int i = 0; i < 8; i++)
      cycle((i >= 2 && i < 5), 1'b1, AW'(i + 2), $urandom, 1'b1, AW'(i + 20), $urandom);
    idle_cycle();

    // Requester 1 arrives late while requester 0 has saturated its burst.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, AW'(i + 1), $urandom, (i >= 5), 5'd9, $urandom);
      if (i == 5) check_val("late_win", {63'd0, gnt_id}, 64'd1);
    end
    idle_cycle();

    // Asynchronous reset between edges while a write is on the port.
    cycle(1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_we", {63'd0, we}, 64'd0);
    check_val("arst_waddr", 64'(waddr), 64'd0);
    check_val("arst_wdata", 64'(wdata), 64'd0);
    check_val("arst_gnt_id", {63'd0, gnt_id}, 64'd0);
    check_val("arst_r0", {63'd0, r0}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 1'b1, 5'd11, 32'h55, 1'b1, 5'd12, 32'h66);
`ifdef WB_ARB_FIXED_PRIO_EN
    check_val("post_rst_gnt", {63'd0, gnt_id}, 64'd1);
`else
    check_val("post_rst_gnt", {63'd0, gnt_id}, 64'd0);
`endif

    // Randomized traffic; requesters hold their request until granted.
    p0 = 1'b0; p1 = 1'b0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0) begin
        p0  = ($urandom_range(0, 3) != 0);
        ra0 = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        rd0 = $urandom;
      end
      if (!p1) begin
        p1  = ($urandom_range(0, 3) != 0);
        ra1 = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        rd1 = $urandom;
      end
      cycle(($urandom_range(0, 7) == 0), p0, ra0, rd0, p1, ra1, rd1);
      if (mg == 0) p0 = 1'b0;
      if (mg == 1) p1 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and sequencer for the register-file write-back port. Two writers share the single write port and its 2:1 select datapath:
- requester 0: ALU result
- requester 1: load/memory result

The block chooses one requester per cycle with a valid/ready handshake and registers the winning address and data onto the port. A burst limit stops either requester from starving the other.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- MAX_BURST, 4, max consecutive grants to one requester while the other waits (legal 1..15)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hazard-unit stall; blocks all grants this cycle
- v0  input  1  requester 0 valid
- a0  input  ADDR_W  requester 0 destination register
- d0  input  DATA_W  requester 0 write data
- r0  output  1  requester 0 ready (combinational grant)
- v1, a1, d1, r1  same as the requester 0 set, for requester 1
- we  output  1  register-file write enable (registered)
- waddr  output  ADDR_W  register-file write address (registered)
- wdata  output  DATA_W  register-file write data (registered)
- gnt_id  output  1  requester that produced the current we/waddr/wdata (registered)

## Operation
- Owner FSM states:
  - IDLE: no grant last cycle.
  - OWN0: last grant went to requester 0.
  - OWN1: last grant went to requester 1.
- cnt is a 4-bit count of consecutive grants to the current owner.
- Grant decision is combinational, and only when stall=0:
  - Neither valid: no grant.
  - Exactly one valid: grant that requester, regardless of cnt.
  - Both valid, state IDLE: grant 0.
  - Both valid, state OWNk, cnt < MAX_BURST: grant k.
  - Both valid, state OWNk, cnt >= MAX_BURST: grant the other requester.
- rk=1 only for the granted requester. A transfer occurs when vk & rk.
- On a transfer from k, at the next edge:
  - waddr<=ak, wdata<=dk, gnt_id<=k.
  - we<=1, except when ak==0, where we<=0 (writes to $zero are accepted but suppressed).
  - State<=OWNk.
  - cnt<=(state==OWNk) ? min(cnt+1, MAX_BURST) : 1.
- No transfer and stall=0: we<=0, state<=IDLE, cnt<=0. waddr/wdata/gnt_id hold.
- stall=1: r0=r1=0, we<=0, state and cnt hold. waddr/wdata/gnt_id hold.
- A requester must hold vk/ak/dk stable until it sees rk=1. The arbiter places no other constraint on requesters.

## Timing
- Reset values (asynchronous, immediate on rst=1): we=0, waddr=0, wdata=0, gnt_id=0, state IDLE, cnt=0. r0=r1=0 while rst=1.
- Latency: accept in cycle N -> we/waddr/wdata valid in cycle N+1. Throughput is one write per cycle.
- r0/r1 depend combinationally on v0, v1, stall, state and cnt. There is no path from a0/a1/d0/d1 to ready.
- Both valid continuously with MAX_BURST=4: grant sequence 0,0,0,0,1,1,1,1,0,...
- Single requester streaming: cnt saturates at MAX_BURST. A newly arriving other requester wins on its first valid cycle.
- MAX_BURST=1: strict alternation whenever both are valid.
- Stall mid-burst: burst position is preserved, and the count resumes after the stall is released.
- Reset asserted mid-burst: outputs clear immediately. The first grant after release follows IDLE rules.

## Configuration
- WB_ARB_FIXED_PRIO_EN defined:
  - Requester 1 (load) always wins when both are valid.
  - cnt is held at 0 and MAX_BURST is ignored.
  - Single-valid, stall and $zero rules are unchanged.
- Not defined: round-robin with burst limit as described above.

## Test plan
- Reset, then a single write: rst pulse; v0=1, a0=5, d0=0xDEADBEEF for 1 cycle -> r0=1 in that cycle; next cycle we=1, waddr=5, wdata=0xDEADBEEF, gnt_id=0; the cycle after, we=0.
- Contention: v0=v1=1 held for 10 cycles, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0,0 and r0/r1 never high together. With WB_ARB_FIXED_PRIO_EN -> ten grants to 1 and r0=0 throughout.
- $zero suppression: v1=1, a1=0, d1=0x1234 -> r1=1; next cycle we=0, waddr=0, gnt_id=1.
- Stall: both valid, stall=1 for 3 cycles after two grants to 0 -> r0=r1=0 and we=0 for 3 cycles; after release, 2 more grants to 0, then a switch to 1.
- Late arrival: v0 held 8 cycles alone, v1 rises at cycle 6 -> cycle 6 grants 1 (cnt saturated at 4), then 1 holds for up to 4 grants.
- Async reset mid-burst: rst rises between edges while we=1 -> we, waddr, wdata and gnt_id go to 0 immediately; after release with v0=v1=1, the first grant goes to 0.
